// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event scheduler.
//   evt_type_e   : gesture event code carried on the event stream
//   gest_state_e : per-button gesture FSM state
//   cnt_width()  : hold counter width wide enough for both terminal counts
//   id_width()   : button index width, never below one bit
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_REPEAT = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } gest_state_e;

  function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
    int max_c;
    max_c = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(max_c + 1);
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_gesture_fsm.sv
// One button's gesture recogniser: IDLE -> HELD -> REPEAT with a hold counter.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   down_i      : one-cycle press pulse
//   up_i        : one-cycle release pulse
//   evt_o       : event emitted this cycle (EVT_NONE when nothing happens);
//                 combinational so the pending slot captures it at the next edge
module button_gesture_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      down_i,
  input  logic      up_i,
  output evt_type_e evt_o
);

  localparam int CNT_WIDTH = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);

  gest_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Release is tested before the terminal count so it wins a collision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_o   = EVT_NONE;
    case (state_q)
      IDLE: begin
        if (down_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (up_i) begin
          evt_o   = EVT_SHORT;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          evt_o   = EVT_LONG;
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (up_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_TC) begin
          evt_o = EVT_REPEAT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns per-button press/release pulses into SHORT/LONG/REPEAT events, keeps
// one pending event per button and drains them round-robin onto one stream.
// Ports:
//   clk, arst_n       : clock, asynchronous active-low reset
//   btn_down_i/up_i   : per-button one-cycle press/release pulses
//   evt_valid_o/ready : event stream handshake. An event transfers on a clk
//                       edge where valid && ready; while valid && !ready the
//                       id/type hold steady, and valid never drops without
//                       a transfer.
//   evt_id_o/type_o   : button index and event type of the presented event
//   ovf_o             : sticky per-button "pending event overwritten" flags
//   ovf_clr_i         : synchronous clear of ovf_o (a same-cycle set wins)
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [N_BTN-1:0]              btn_down_i,
  input  logic [N_BTN-1:0]              btn_up_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [id_width(N_BTN)-1:0]    evt_id_o,
  output logic [1:0]                    evt_type_o,
  output logic [N_BTN-1:0]              ovf_o,
  input  logic                          ovf_clr_i
);

  localparam int ID_W = id_width(N_BTN);

  evt_type_e btn_evt [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_gesture_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .clk   (clk),
      .arst_n(arst_n),
      .down_i(btn_down_i[g]),
      .up_i  (btn_up_i[g]),
      .evt_o (btn_evt[g])
    );
  end

  logic [N_BTN-1:0] slot_full_q, slot_full_d;
  evt_type_e        slot_type_q [N_BTN];
  evt_type_e        slot_type_d [N_BTN];
  logic [N_BTN-1:0] ovf_q, ovf_d, ovf_set;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  evt_type_e        type_q, type_d;

  logic             load;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;

  // Output register accepts a new event when empty or when its event leaves.
  assign load = !valid_q || evt_ready_i;

  // First full slot at or after rr_q, wrapping modulo N_BTN.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = ID_W'((int'(rr_q) + k) % N_BTN);
      if (!grant_vld && slot_full_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A slot granted this cycle is free, so a new event refilling it is not
  // an overflow.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_type_d = slot_type_q;
    ovf_set     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_evt[i] != EVT_NONE) begin
        if (slot_full_q[i] && !(load && grant_vld && (grant_idx == ID_W'(i))))
          ovf_set[i] = 1'b1;
        slot_full_d[i] = 1'b1;
        slot_type_d[i] = btn_evt[i];
      end else if (load && grant_vld && (grant_idx == ID_W'(i))) begin
        slot_full_d[i] = 1'b0;
      end
    end
    ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    type_d  = type_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        id_d   = grant_idx;
        type_d = slot_type_q[grant_idx];
        if (grant_idx == ID_W'(N_BTN - 1)) rr_d = '0;
        else                               rr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slot_full_q <= '0;
      for (int i = 0; i < N_BTN; i++) slot_type_q[i] <= EVT_NONE;
      ovf_q   <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= EVT_NONE;
    end else begin
      slot_full_q <= slot_full_d;
      slot_type_q <= slot_type_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      type_q      <= type_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_type_o  = type_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler (4 buttons, LONG=20, REPEAT=8).
// Cycle c is the interval after clock edge c; inputs driven during cycle c are
// sampled at the edge that ends it, and outputs are read 1 time unit after it.
module tb_button_event_scheduler;

  localparam int N   = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [3:0] btn_down = '0;
  logic [3:0] btn_up = '0;
  logic       ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid_o;
  logic [1:0] evt_id_o;
  logic [1:0] evt_type_o;
  logic [3:0] ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  button_event_scheduler #(
    .N_BTN(N), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .arst_n(arst_n), .btn_down_i(btn_down), .btn_up_i(btn_up),
    .evt_valid_o(evt_valid_o), .evt_ready_i(ready), .evt_id_o(evt_id_o),
    .evt_type_o(evt_type_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Gestures are derived from the hold age (cycles since the press was
  // sampled): release at age <= LONG gives SHORT, age == LONG gives LONG,
  // later ages LONG + k*REPEAT give REPEAT.
  bit         m_pressed [4];
  int         m_press_cyc [4];
  bit         m_full [4];
  logic [1:0] m_type [4];
  logic [3:0] m_ovf;
  bit         m_valid;
  logic [1:0] m_id;
  logic [1:0] m_otype;
  int         m_rr;
  logic [3:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pressed[i] = 0; m_press_cyc[i] = 0; m_full[i] = 0; m_type[i] = 2'd0;
    end
    m_ovf = '0; m_valid = 0; m_id = '0; m_otype = '0; m_rr = 0;
  endtask

  task automatic model_step();
    logic [1:0] ev [4];
    logic [1:0] gt;
    logic [3:0] sets;
    bit gv, ld, hit;
    int g, j, age;
    for (int i = 0; i < 4; i++) begin
      ev[i] = 2'd0;
      if (m_pressed[i]) begin
        age = cyc - m_press_cyc[i];
        if (btn_up[i]) begin
          if (age <= LNG) ev[i] = 2'd1;
          m_pressed[i] = 0;
        end else if (age == LNG) ev[i] = 2'd2;
        else if (age > LNG && ((age - LNG) % REP) == 0) ev[i] = 2'd3;
      end else if (btn_down[i]) begin
        m_pressed[i] = 1;
        m_press_cyc[i] = cyc;
      end
    end
    ld = !m_valid || ready;
    gv = 0; g = 0;
    for (int k = 0; k < 4; k++) begin
      j = (m_rr + k) % 4;
      if (!gv && m_full[j]) begin gv = 1; g = j; end
    end
    if (m_valid && ready) exp_q.push_back({m_id, m_otype});
    gt = m_type[g];
    sets = '0;
    for (int i = 0; i < 4; i++) begin
      hit = ld && gv && (g == i);
      if (ev[i] != 2'd0) begin
        if (m_full[i] && !hit) sets[i] = 1'b1;
        m_full[i] = 1; m_type[i] = ev[i];
      end else if (hit) m_full[i] = 0;
    end
    m_ovf = (ovf_clr ? 4'd0 : m_ovf) | sets;
    if (ld) begin
      m_valid = gv;
      if (gv) begin m_id = 2'(g); m_otype = gt; m_rr = (g + 1) % 4; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!arst_n) model_reset();
    else model_step();
    cyc++;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_n = 1'b0; ready = 1'b1; btn_down = '0; btn_up = '0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({evt_valid_o, evt_id_o, evt_type_o, ovf_o} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b id=%0d t=%0d ovf=%b expected all 0",
               evt_valid_o, evt_id_o, evt_type_o, ovf_o);
    end
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_short();
    int nv = 0, vc = -1;
    logic [1:0] vid = '0, vt = '0;
    for (int c = 0; c < 13; c++) begin
      btn_down = (c == 0) ? 4'b0010 : 4'b0000;
      btn_up   = (c == 5) ? 4'b0010 : 4'b0000;
      tick();
      if (evt_valid_o) begin nv++; vc = c + 1; vid = evt_id_o; vt = evt_type_o; end
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (nv != 1 || vc != 7) begin
      n_fail++;
      $display("FAIL short_timing: got %0d valid cycles last at %0d expected 1 at 7", nv, vc);
    end
    n_checks++;
    if (vid !== 2'd1 || vt !== 2'd1) begin
      n_fail++;
      $display("FAIL short_event: got id=%0d type=%0d expected id=1 type=1", vid, vt);
    end
  endtask

  task automatic test_long();
    int ecyc [$];
    logic [1:0] etyp [$];
    int exp_c [4] = '{22, 30, 38, 46};
    logic [1:0] exp_t [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int c = 0; c < 56; c++) begin
      btn_down = (c == 0)  ? 4'b0100 : 4'b0000;
      btn_up   = (c == 45) ? 4'b0100 : 4'b0000;
      tick();
      if (evt_valid_o) begin
        ecyc.push_back(c + 1); etyp.push_back(evt_type_o);
        n_checks++;
        if (evt_id_o !== 2'd2) begin
          n_fail++;
          $display("FAIL long_id: got %0d expected 2", evt_id_o);
        end
      end
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (ecyc.size() != 4) begin
      n_fail++;
      $display("FAIL long_count: got %0d events expected 4", ecyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < ecyc.size()) begin
        n_checks++;
        if (ecyc[k] != exp_c[k] || etyp[k] !== exp_t[k]) begin
          n_fail++;
          $display("FAIL long_event%0d: got cycle %0d type %0d expected cycle %0d type %0d",
                   k, ecyc[k], etyp[k], exp_c[k], exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_collision();
    int offs [2] = '{19, 20};
    foreach (offs[o]) begin
      int nv = 0, vc = -1;
      logic [1:0] vid = '0, vt = '0;
      for (int c = 0; c < offs[o] + 10; c++) begin
        btn_down = (c == 0)       ? 4'b0001 : 4'b0000;
        btn_up   = (c == offs[o]) ? 4'b0001 : 4'b0000;
        tick();
        if (evt_valid_o) begin nv++; vc = c + 1; vid = evt_id_o; vt = evt_type_o; end
      end
      btn_down = '0; btn_up = '0;
      n_checks++;
      if (nv != 1 || vc != offs[o] + 2 || vid !== 2'd0 || vt !== 2'd1) begin
        n_fail++;
        $display("FAIL collision_up%0d: got n=%0d cyc=%0d id=%0d type=%0d expected n=1 cyc=%0d id=0 type=1",
                 offs[o], nv, vc, vid, vt, offs[o] + 2);
      end
    end
  endtask

  task automatic test_round_robin();
    int ecyc [$];
    logic [1:0] eid [$];
    int exp_c [3] = '{5, 6, 7};
    logic [1:0] exp_i [3] = '{2'd2, 2'd3, 2'd0};
    // A grant to button 1 leaves the pointer at 2.
    for (int c = 0; c < 8; c++) begin
      btn_down = (c == 0) ? 4'b0010 : 4'b0000;
      btn_up   = (c == 2) ? 4'b0010 : 4'b0000;
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      btn_down = (c == 0) ? 4'b1101 : 4'b0000;
      btn_up   = (c == 3) ? 4'b1101 : 4'b0000;
      tick();
      if (evt_valid_o) begin
        ecyc.push_back(c + 1); eid.push_back(evt_id_o);
        n_checks++;
        if (evt_type_o !== 2'd1) begin
          n_fail++;
          $display("FAIL rr_type: got %0d expected 1", evt_type_o);
        end
      end
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (ecyc.size() != 3) begin
      n_fail++;
      $display("FAIL rr_count: got %0d expected 3", ecyc.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (k < ecyc.size()) begin
        n_checks++;
        if (ecyc[k] != exp_c[k] || eid[k] !== exp_i[k]) begin
          n_fail++;
          $display("FAIL rr_order%0d: got cycle %0d id %0d expected cycle %0d id %0d",
                   k, ecyc[k], eid[k], exp_c[k], exp_i[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int first_v = -1;
    bit stable_ok = 1;
    logic [3:0] ovf_early = 'x;
    ready = 1'b0;
    for (int c = 0; c < 41; c++) begin
      btn_down = (c == 0)  ? 4'b0010 : 4'b0000;
      btn_up   = (c == 40) ? 4'b0010 : 4'b0000;
      tick();
      if (evt_valid_o && first_v < 0) first_v = c + 1;
      if (c + 1 >= 22 && !(evt_valid_o === 1'b1 && evt_id_o === 2'd1 && evt_type_o === 2'd2))
        stable_ok = 0;
      if (c + 1 == 36) ovf_early = ovf_o;
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (first_v != 22) begin
      n_fail++;
      $display("FAIL bp_first_valid: got cycle %0d expected 22", first_v);
    end
    n_checks++;
    if (!stable_ok) begin
      n_fail++;
      $display("FAIL bp_stable: got id/type change while stalled expected id=1 type=2 held");
    end
    n_checks++;
    if (ovf_early !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_ovf_before: got %b expected 0000", ovf_early);
    end
    n_checks++;
    if (ovf_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_ovf_set: got %b expected 0010", ovf_o);
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1 || evt_type_o !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%0b id=%0d t=%0d expected v=1 id=1 t=3",
               evt_valid_o, evt_id_o, evt_type_o);
    end
    tick();
    n_checks++;
    if (evt_valid_o !== 1'b0 || ovf_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%0b ovf=%b expected v=0 ovf=0010", evt_valid_o, ovf_o);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_ovf_clr: got %b expected 0000", ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    int vc = -1;
    logic [1:0] vid = '0, vt = '0;
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      btn_down = (c == 0) ? 4'b1001 : 4'b0000;
      btn_up   = (c == 7) ? 4'b0001 : 4'b0000;
      tick();
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (evt_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_valid: got %0b expected 1", evt_valid_o);
    end
    arst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({evt_valid_o, evt_id_o, evt_type_o, ovf_o} !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%0b id=%0d t=%0d ovf=%b expected all 0",
               evt_valid_o, evt_id_o, evt_type_o, ovf_o);
    end
    repeat (3) tick();
    arst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (evt_valid_o) nv++;
    end
    n_checks++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rst_no_long: got %0d valid cycles expected 0", nv);
    end
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      btn_down = (c == 0) ? 4'b1000 : 4'b0000;
      btn_up   = (c == 3) ? 4'b1000 : 4'b0000;
      tick();
      if (evt_valid_o) begin nv++; vc = c + 1; vid = evt_id_o; vt = evt_type_o; end
    end
    btn_down = '0; btn_up = '0;
    n_checks++;
    if (nv != 1 || vc != 5 || vid !== 2'd3 || vt !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_fresh_short: got n=%0d cyc=%0d id=%0d t=%0d expected n=1 cyc=5 id=3 t=1",
               nv, vc, vid, vt);
    end
  endtask

  task automatic test_random();
    logic [3:0] dut_item, exp_item;
    bit dut_hs;
    int bad_lock = 0;
    exp_q.delete();
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < 4; i++) begin
        btn_down[i] = ($urandom_range(0, 9) == 0);
        btn_up[i]   = ($urandom_range(0, 24) == 0);
      end
      ready   = (it < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 39) == 0);
      dut_hs   = evt_valid_o && ready;
      dut_item = {evt_id_o, evt_type_o};
      tick();
      if (dut_hs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_event: got id=%0d t=%0d expected none", dut_item[3:2], dut_item[1:0]);
        end else begin
          exp_item = exp_q.pop_front();
          if (dut_item !== exp_item) begin
            n_fail++;
            $display("FAIL rand_event: got id=%0d t=%0d expected id=%0d t=%0d",
                     dut_item[3:2], dut_item[1:0], exp_item[3:2], exp_item[1:0]);
          end
        end
      end
      n_checks++;
      if (evt_valid_o !== m_valid || ovf_o !== m_ovf ||
          (m_valid && (evt_id_o !== m_id || evt_type_o !== m_otype))) begin
        n_fail++;
        if (bad_lock < 10)
          $display("FAIL rand_lockstep@%0d: got v=%0b id=%0d t=%0d ovf=%b expected v=%0b id=%0d t=%0d ovf=%b",
                   it, evt_valid_o, evt_id_o, evt_type_o, ovf_o, m_valid, m_id, m_otype, m_ovf);
        bad_lock++;
      end
    end
    btn_down = '0; btn_up = '0; ovf_clr = 1'b0; ready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_missing: got %0d undelivered expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_collision();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
